vec_dot_mac: RTL and testbench
==============================

VEC_DOT_MAC -- requirements
Module: vec_dot_mac

Interface
REQ-001 Parameter N, default 3: number of vector elements, range 2..16.
REQ-002 Parameter W, default 8: element width in bits, range 2..32.
REQ-003 Localparam OW = 2*W + $clog2(N) + 1: accumulator and result width.
REQ-004 The block SHALL use one clock, clk, with all state on the rising edge.
REQ-005 Reset SHALL be asynchronous and active-low, named rst, polarity fixed (0 = reset).
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request a dot product; sampled only in IDLE.
REQ-009 signed_mode  input  1  1 = two's-complement elements, 0 = unsigned; sampled with start.
REQ-010 accum  input  1  1 = add the new dot product to the current out, 0 = start from zero; sampled with start.
REQ-011 A  input  N*W  packed vector; element i = A[i*W +: W].
REQ-012 B  input  N*W  packed vector; element i = B[i*W +: W].
REQ-013 busy  output  1  high while a computation is in progress.
REQ-014 done  output  1  one-cycle pulse when out is updated.
REQ-015 out  output  OW  result, held until the next completion or reset.
REQ-016 ovf  output  1  overflow flag for the last result, valid from done onward.

Function
REQ-017 FSM states: IDLE, MAC. Reset state is IDLE.
REQ-018 On a rising edge in IDLE with start=1:
- capture A, B, signed_mode and accum into internal registers;
- load acc with out if accum=1, otherwise with 0;
- clear idx to 0;
- clear ovf;
- set busy=1 and go to MAC.
REQ-019 On each MAC edge, acc SHALL be updated to acc + ext(a[idx])*ext(b[idx]), and idx SHALL increment.
- ext = sign-extension to OW when signed_mode=1, zero-extension otherwise.
REQ-020 All arithmetic SHALL be modulo 2^OW; a single non-accumulating pass never overflows.
REQ-021 On the MAC edge where idx = N-1:
- out is set to the final sum;
- done=1 and busy=0 for the following cycle;
- the state returns to IDLE.
REQ-022 Latency: done SHALL be high exactly N cycles after the start edge; throughput is one result per N+1 cycles minimum.
REQ-023 done SHALL be high for exactly one cycle per computation.
REQ-024 start while busy=1 SHALL be ignored; no queuing.
REQ-025 start=1 in the cycle where done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-026 A and B changes while busy SHALL NOT affect the result, because the operands are captured at start.
REQ-027 ovf SHALL be set with done if the mathematically exact sum (prior out + products) lies outside the OW-bit range:
- signed range when signed_mode=1;
- unsigned range when signed_mode=0.
REQ-028 out SHALL hold the wrapped value when ovf=1.
REQ-029 In the idle state, out, ovf and done SHALL change only as specified above.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, busy=0, done=0, out=0, ovf=0, acc=0, idx=0.
REQ-031 Reset mid-computation SHALL abandon the operation with no done pulse; the next start after rst=1 SHALL behave as the first after power-up.
REQ-032 start SHALL be ignored while rst=0.

Verification (N=3, W=8, OW=19)
REQ-033 Unsigned, accum=0, A=B={3,2,1} (element 0 = 1) -> done 3 cycles after start edge, out=14, ovf=0, busy high for 3 cycles.
REQ-034 Unsigned, A=B={2,5,10} -> out=129; then accum=1 with the same operands -> out=258.
REQ-035 Signed, A elements {-1,2,-3} (8'hFF,8'h02,8'hFD), B={1,2,3} -> out = -6 (19'h7FFFA), ovf=0.
REQ-036 Unsigned, A=B=all 8'hFF:
- accum=0 -> out=195075;
- accum=1 -> out=390150, ovf=0;
- accum=1 again -> out=60937, ovf=1.
REQ-037 start pulsed again during MAC, with A/B changed mid-run -> a single done and the original result; start coincident with done -> second result N cycles later.
REQ-038 rst driven low for 1 cycle during the second MAC cycle -> busy=0, out=0, no done; a following start with {1,2,3}·{1,2,3} -> out=14.

Source files
------------

// File: rtl/vec_dot_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_dot_mac_if
// Description : Request/result bundle for vec_dot_mac.
//               master : start, signed_mode, accum, A, B out; busy, done,
//                        out, ovf in.
//               slave  : the mirror image, used by the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface vec_dot_mac_if #(
    parameter int N = 3,
    parameter int W = 8
);
    localparam int OW = 2*W + $clog2(N) + 1;

    logic              start;
    logic              signed_mode;
    logic              accum;
    logic [N*W-1:0]    A;
    logic [N*W-1:0]    B;
    logic              busy;
    logic              done;
    logic [OW-1:0]     out;
    logic              ovf;

    modport master (
        output start, signed_mode, accum, A, B,
        input  busy, done, out, ovf
    );

    modport slave (
        input  start, signed_mode, accum, A, B,
        output busy, done, out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/vec_dot_mac.sv
`default_nettype none
// ============================================================================
// Module      : vec_dot_mac
// Description : Sequential N-element dot product with optional accumulation
//               onto the previous result and overflow detection.
//               One element pair is multiplied and accumulated per cycle.
// Ports       : clk  - system clock (rising edge)
//               rst  - asynchronous active-low reset
//               bus  - vec_dot_mac_if.slave (start/signed_mode/accum/A/B in,
//                      busy/done/out/ovf out)
// Revision    : 1.0 - initial release
// ============================================================================
module vec_dot_mac #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    vec_dot_mac_if.slave    bus
);
    localparam int OW   = 2*W + $clog2(N) + 1;
    // Two guard bits above OW hold the exact (non-wrapped) running sum, so
    // overflow of the final OW-bit result can be judged at completion.
    localparam int c_XW = OW + 2;
    localparam int c_IW = $clog2(N);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_t;

    state_t              r_state;
    logic [N*W-1:0]      r_a;
    logic [N*W-1:0]      r_b;
    logic                r_sm;
    logic [c_XW-1:0]     r_acc;
    logic [c_IW-1:0]     r_idx;
    logic                r_busy;
    logic                r_done;
    logic [OW-1:0]       r_out;
    logic                r_ovf;

    logic [W-1:0]        w_a_el;
    logic [W-1:0]        w_b_el;
    logic [c_XW-1:0]     w_ea;
    logic [c_XW-1:0]     w_eb;
    logic [c_XW-1:0]     w_prod;
    logic [c_XW-1:0]     w_sum;
    logic [c_XW-1:0]     w_prior;
    logic                w_fits;

    assign w_a_el = r_a[r_idx*W +: W];
    assign w_b_el = r_b[r_idx*W +: W];

    assign w_ea = r_sm ? {{(c_XW-W){w_a_el[W-1]}}, w_a_el} : {{(c_XW-W){1'b0}}, w_a_el};
    assign w_eb = r_sm ? {{(c_XW-W){w_b_el[W-1]}}, w_b_el} : {{(c_XW-W){1'b0}}, w_b_el};

    // Low c_XW bits of the product are exact for both signed and unsigned
    // operands in two's-complement arithmetic.
    assign w_prod = w_ea * w_eb;
    assign w_sum  = r_acc + w_prod;

    // Previous result interpreted in the mode of the new request.
    assign w_prior = bus.signed_mode ? {{2{r_out[OW-1]}}, r_out} : {2'b00, r_out};

    // Signed fit: top three bits all equal. Unsigned fit: guard bits zero.
    assign w_fits = r_sm ? ((&w_sum[c_XW-1:OW-1]) | ~(|w_sum[c_XW-1:OW-1]))
                         : ~(|w_sum[c_XW-1:OW]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sm    <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_sm    <= bus.signed_mode;
                        r_acc   <= bus.accum ? w_prior : '0;
                        r_idx   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + c_IW'(1);
                    if (r_idx == c_LAST) begin
                        r_out   <= w_sum[OW-1:0];
                        r_ovf   <= ~w_fits;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vec_dot_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_dot_mac
// Description : Directed self-checking bench for vec_dot_mac (N=3, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_dot_mac;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int OW = 2*W + $clog2(N) + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    vec_dot_mac_if #(.N(N), .W(W)) bus ();

    vec_dot_mac #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] e2, input logic [W-1:0] e1,
                                          input logic [W-1:0] e0);
        return {e2, e1, e0};
    endfunction

    // Drive a request before a rising edge; returns #1 after the start edge.
    task automatic start_op(input logic sm, input logic ac,
                            input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.accum       = ac;
        bus.A           = a;
        bus.B           = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Called #1 after a start edge: checks busy/done timing and the result.
    task automatic wait_done(input string tag, input logic [OW-1:0] eo, input logic eovf);
        chk({tag, "_busy0"}, 64'(bus.busy), 64'd1);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (k < N) begin
                chk($sformatf("%s_nodone%0d", tag, k), 64'(bus.done), 64'd0);
            end else begin
                chk({tag, "_done"}, 64'(bus.done), 64'd1);
                chk({tag, "_busyend"}, 64'(bus.busy), 64'd0);
                chk({tag, "_out"}, 64'(bus.out), 64'(eo));
                chk({tag, "_ovf"}, 64'(bus.ovf), 64'(eovf));
            end
        end
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.start       = 1'b1;     // must be ignored under reset
        bus.signed_mode = 1'b0;
        bus.accum       = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_out",  64'(bus.out),  64'd0);
        chk("rst_ovf",  64'(bus.ovf),  64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1 chk("idle_busy", 64'(bus.busy), 64'd0);

        // 1+4+9
        start_op(1'b0, 1'b0, pk(8'd3, 8'd2, 8'd1), pk(8'd3, 8'd2, 8'd1));
        wait_done("u14", 19'd14, 1'b0);

        // 4+25+100, then accumulated onto itself
        start_op(1'b0, 1'b0, pk(8'd2, 8'd5, 8'd10), pk(8'd2, 8'd5, 8'd10));
        wait_done("u129", 19'd129, 1'b0);
        start_op(1'b0, 1'b1, pk(8'd2, 8'd5, 8'd10), pk(8'd2, 8'd5, 8'd10));
        wait_done("acc258", 19'd258, 1'b0);

        // -1*1 + 2*2 + -3*3 = -6
        start_op(1'b1, 1'b0, pk(8'hFF, 8'h02, 8'hFD), pk(8'd1, 8'd2, 8'd3));
        wait_done("sneg6", 19'h7FFFA, 1'b0);

        // 3*255*255 = 195075; x2 = 390150; x3 = 585225 - 524288 = 60937 (wrap)
        start_op(1'b0, 1'b0, {N{8'hFF}}, {N{8'hFF}});
        wait_done("ff1", 19'd195075, 1'b0);
        start_op(1'b0, 1'b1, {N{8'hFF}}, {N{8'hFF}});
        wait_done("ff2", 19'd390150, 1'b0);
        start_op(1'b0, 1'b1, {N{8'hFF}}, {N{8'hFF}});
        wait_done("ff3", 19'd60937, 1'b1);

        // Start and operand changes while busy are ignored.
        start_op(1'b0, 1'b0, pk(8'd3, 8'd2, 8'd1), pk(8'd3, 8'd2, 8'd1));
        @(posedge clk);
        #1;
        bus.A     = {N{8'hFF}};
        bus.B     = {N{8'hFF}};
        bus.start = 1'b1;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("mid_nodone", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_done", 64'(bus.done), 64'd1);
        chk("mid_out",  64'(bus.out),  64'd14);
        // Start coincident with done is accepted: 1+1+1 = 3.
        bus.start = 1'b1;
        bus.accum = 1'b0;
        bus.A     = pk(8'd1, 8'd1, 8'd1);
        bus.B     = pk(8'd1, 8'd1, 8'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("coinc", 19'd3, 1'b0);

        // Reset during the second MAC cycle abandons the operation.
        start_op(1'b0, 1'b0, {N{8'hFF}}, {N{8'hFF}});
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_out",  64'(bus.out),  64'd0);
        chk("mrst_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k <= N; k++) begin
            @(posedge clk);
            #1 chk($sformatf("mrst_nodone%0d", k), 64'(bus.done), 64'd0);
        end
        start_op(1'b0, 1'b0, pk(8'd3, 8'd2, 8'd1), pk(8'd3, 8'd2, 8'd1));
        wait_done("post_rst", 19'd14, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
